maze_map_writer: RTL and testbench

- Write side of the 30x21 maze map that the game renderer reads row-by-row.
- On a start pulse it does two things:
  - Fills every map row with walls.
  - Carves a pseudo-random connected path from the player spawn cell to the right-hand edge, emitting row writes into the dual-port map RAM.
- The renderer reads the other RAM port, so a new level is generated without reloading the ROM image.
- Map encoding matches the renderer: a 30-bit row word per row address, bit x = 1 means wall, 0 means floor.

---
 rtl/maze_pkg.sv | 25 ++
 rtl/lfsr16.sv | 19 +
 rtl/maze_map_writer.sv | 116 +++++++++++
 tb/tb_maze_map_writer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// maze_pkg: shared map geometry, FSM/move encodings and the LFSR step for the maze generator.
package maze_pkg;
  localparam int MAP_WIDTH = 30;
  localparam int MAP_HEIGHT = 21;
  localparam int ADDR_W = $clog2(MAP_HEIGHT);
  localparam int X_W = $clog2(MAP_WIDTH);
  localparam int START_X = 0;
  localparam int START_Y = 11;
  localparam logic [1:0] MOVE_UP = 2'b00;
  localparam logic [1:0] MOVE_DOWN = 2'b01;
  typedef enum logic [4:0] {
    IDLE  = 5'b00001,
    CLEAR = 5'b00010,
    CARVE = 5'b00100,
    STEP  = 5'b01000,
    DONE  = 5'b10000
  } state_t;
  // Fibonacci x^16+x^14+x^13+x^11+1, shifting left with feedback into bit 0
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction
  function automatic logic [1:0] next_move(input logic [15:0] s);
    return 2'(lfsr_next(s));
  endfunction
endpackage

// File: rtl/lfsr16.sv
// lfsr16: 16-bit Fibonacci LFSR with synchronous load and step enable.
module lfsr16
  import maze_pkg::*;
#(
  parameter logic [15:0] RESET_VAL = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        advance,
  output logic [15:0] q
);
  always_ff @(posedge clk) begin
    if (!reset) q <= RESET_VAL;
    else if (load) q <= seed;
    else if (advance) q <= lfsr_next(q);
  end
endmodule

// File: rtl/maze_map_writer.sv
// maze_map_writer: walls every map row, then carves a random walk from spawn to the right edge,
// streaming each touched row word to the map RAM write port.
module maze_map_writer
  import maze_pkg::*;
#(
  parameter int          SPAWN_X      = START_X,
  parameter int          SPAWN_Y      = START_Y,
  parameter int          MAX_STEPS    = 255,
  parameter logic [15:0] DEFAULT_SEED = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [15:0]          seed,
  input  logic                 wr_ready,
  output logic                 wr_en,
  output logic [ADDR_W-1:0]    wr_addr,
  output logic [MAP_WIDTH-1:0] wr_data,
  output logic                 busy,
  output logic                 done,
  output logic [7:0]           step_count
);
  localparam logic [7:0] STEP_MAX = 8'(MAX_STEPS);
  localparam logic [X_W-1:0] LAST_X = X_W'(MAP_WIDTH - 1);
  localparam logic [ADDR_W-1:0] LAST_Y = ADDR_W'(MAP_HEIGHT - 1);
  state_t state_q;
  logic [MAP_WIDTH-1:0] shadow_q [MAP_HEIGHT];
  logic [ADDR_W-1:0] row_q, cy_q, cy_d, ty;
  logic [X_W-1:0] cx_q, cx_d, tx;
  logic [7:0] step_q, step_d;
  logic wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [MAP_WIDTH-1:0] wr_data_q, carve_row;
  logic [15:0] lfsr_q;
  logic [1:0] mv;
  logic go_right;
  lfsr16 #(.RESET_VAL(DEFAULT_SEED)) u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .load    (state_q == IDLE && start),
    .seed    (seed == '0 ? DEFAULT_SEED : seed),
    .advance (state_q == STEP),
    .q       (lfsr_q)
  );
  // Next cell is resolved in STEP so the carve write can be registered on the way into CARVE.
  always_comb begin
    mv = next_move(lfsr_q);
    go_right = step_q == STEP_MAX || mv[1] || (mv == MOVE_UP && cy_q == '0) ||
               (mv == MOVE_DOWN && cy_q == LAST_Y);
    cx_d = go_right ? cx_q + 1'b1 : cx_q;
    cy_d = go_right ? cy_q : (mv == MOVE_DOWN ? cy_q + 1'b1 : cy_q - 1'b1);
    step_d = step_q == STEP_MAX ? step_q : step_q + 1'b1;
    tx = state_q == STEP ? cx_d : cx_q;
    ty = state_q == STEP ? cy_d : cy_q;
    carve_row = (state_q == CLEAR ? '1 : shadow_q[ty]) & ~(MAP_WIDTH'(1) << tx);
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      step_q    <= '0;
      row_q     <= '0;
      cx_q      <= '0;
      cy_q      <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_q   <= CLEAR;
          step_q    <= '0;
          row_q     <= '0;
          cx_q      <= X_W'(SPAWN_X);
          cy_q      <= ADDR_W'(SPAWN_Y);
          wr_en_q   <= 1'b1;
          wr_addr_q <= '0;
          wr_data_q <= '1;
        end
        CLEAR: if (wr_ready) begin
          shadow_q[row_q] <= '1;
          if (row_q == LAST_Y) begin
            state_q          <= CARVE;
            wr_addr_q        <= cy_q;
            wr_data_q        <= carve_row;
            shadow_q[cy_q]   <= carve_row;
          end else begin
            row_q     <= row_q + 1'b1;
            wr_addr_q <= row_q + 1'b1;
          end
        end
        CARVE: if (wr_ready) begin
          wr_en_q <= 1'b0;
          state_q <= cx_q == LAST_X ? DONE : STEP;
        end
        STEP: begin
          state_q        <= CARVE;
          cx_q           <= cx_d;
          cy_q           <= cy_d;
          step_q         <= step_d;
          wr_en_q        <= 1'b1;
          wr_addr_q      <= cy_d;
          wr_data_q      <= carve_row;
          shadow_q[cy_d] <= carve_row;
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign busy       = state_q inside {CLEAR, CARVE, STEP};
  assign done       = state_q == DONE;
  assign step_count = step_q;
endmodule

// File: tb/tb_maze_map_writer.sv
// tb_maze_map_writer: three generator instances (default, no random budget, spawn on row 0)
// checked write-by-write against a reference walk held in per-instance scoreboards.
module tb_maze_map_writer;
  localparam int N = 3;
  localparam int W = 30;
  localparam int H = 21;
  typedef struct packed {
    logic [4:0]  a;
    logic [29:0] d;
  } wr_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic wr_ready;
  logic [N-1:0] start = '0;
  logic [15:0] seed = '0;
  logic [N-1:0] wr_en, busy, done;
  logic [4:0] wr_addr [N];
  logic [29:0] wr_data [N];
  logic [7:0] step_count [N];
  int checks = 0;
  int fails = 0;
  int bp = 0;
  int ph = 0;
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask
  function automatic wr_t mk(input int a, input logic [29:0] d);
    return {5'(a), d};
  endfunction
  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int MS = g == 1 ? 0 : 255;
    localparam int SY = g == 2 ? 0 : 11;
    wr_t q[$];
    wr_t held;
    bit active = 0;
    bit stall = 0;
    int exp_steps = 0;
    int acc = 0;
    int dn = 0;
    maze_map_writer #(.MAX_STEPS(MS), .SPAWN_Y(SY)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start[g]),
      .seed       (seed),
      .wr_ready   (wr_ready),
      .wr_en      (wr_en[g]),
      .wr_addr    (wr_addr[g]),
      .wr_data    (wr_data[g]),
      .busy       (busy[g]),
      .done       (done[g]),
      .step_count (step_count[g])
    );
    // Reference: wall the whole map, then walk cell by cell, recording every row write.
    task automatic gen(input logic [15:0] s);
      logic [29:0] m [H];
      logic [15:0] l;
      int x, y, n, mv;
      l = s == 0 ? 16'hACE1 : s;
      x = 0;
      y = SY;
      n = 0;
      q.delete();
      for (int r = 0; r < H; r++) begin
        m[r] = '1;
        q.push_back(mk(r, m[r]));
      end
      forever begin
        m[y][x] = 1'b0;
        q.push_back(mk(y, m[y]));
        if (x == W - 1) break;
        l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
        mv = int'(l[1:0]);
        if (n == MS || mv >= 2 || (mv == 0 && y == 0) || (mv == 1 && y == H - 1)) x++;
        else y += mv == 0 ? -1 : 1;
        if (n < MS) n++;
      end
      exp_steps = n;
    endtask
    always @(negedge clk) begin
      wr_t e;
      if (!reset) begin
        q.delete();
        active = 0;
        stall = 0;
      end else begin
        if (stall) begin
          chk("hold_wr_en", wr_en[g], 1);
          chk("hold_word", {wr_addr[g], wr_data[g]}, {held.a, held.d});
        end
        if (wr_en[g] && wr_ready) begin
          chk("addr_range", wr_addr[g] < 5'd21, 1);
          chk("unexpected_write", q.size() > 0, 1);
          if (q.size() > 0) begin
            e = q.pop_front();
            chk("wr_addr", wr_addr[g], e.a);
            chk("wr_data", wr_data[g], e.d);
            acc++;
          end
        end
        stall = wr_en[g] && !wr_ready;
        held = {wr_addr[g], wr_data[g]};
        if (done[g]) begin
          dn++;
          chk("done_busy", busy[g], 0);
          chk("done_wr_en", wr_en[g], 0);
          chk("step_count", step_count[g], exp_steps);
          chk("writes_left", q.size(), 0);
          active = 0;
        end else if (start[g] && !active) begin
          active = 1;
          acc = 0;
          gen(seed);
        end
      end
    end
  end
  initial begin
    wr_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      ph++;
      wr_ready = bp == 0 ? 1'b1 : bp == 1 ? (ph % 4 == 0 || ph % 4 == 3) : 1'($urandom_range(0, 1));
    end
  end
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic go(input int g, input logic [15:0] s);
    seed = s;
    start[g] = 1'b1;
    tick();
    start[g] = 1'b0;
  endtask
  task automatic wait_done(input int g);
    int k = 0;
    while (!done[g] && k < 5000) begin
      tick();
      k++;
    end
    chk("done_seen", done[g], 1);
  endtask
  initial begin
    logic [15:0] s;
    int k, d0;
    tick(3);
    for (int g = 0; g < N; g++) begin
      chk("rst_wr_en", wr_en[g], 0);
      chk("rst_busy", busy[g], 0);
      chk("rst_done", done[g], 0);
      chk("rst_step", step_count[g], 0);
      chk("rst_addr", wr_addr[g], 0);
      chk("rst_data", wr_data[g], 0);
    end
    reset = 1'b1;
    tick(2);
    go(1, 16'h0);
    k = 1;
    while (!done[1] && k < 300) begin
      tick();
      k++;
    end
    chk("straight_done_cycle", k, 81);
    chk("straight_writes", g_dut[1].acc, 51);
    tick();
    go(0, 16'hACE1);
    wait_done(0);
    tick();
    repeat (4) begin
      s = 16'($urandom);
      s[0] = 1'b0;
      s[10] = s[15] ^ s[13] ^ s[12];
      go(2, s);
      wait_done(2);
      tick();
    end
    for (int m = 0; m < 3; m++) begin
      bp = m;
      for (int g = 0; g < N; g++) begin
        go(g, m == 0 ? 16'h1234 : 16'($urandom));
        wait_done(g);
        tick();
      end
    end
    bp = 1;
    go(0, 16'h1234);
    wait_done(0);
    tick();
    bp = 0;
    tick();
    d0 = g_dut[0].dn;
    go(0, 16'($urandom));
    tick(9);
    seed = 16'h5A5A;
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    wait_done(0);
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    tick(3);
    chk("done_once", g_dut[0].dn - d0, 1);
    chk("start_in_done_ignored", busy[0], 0);
    s = 16'($urandom);
    go(0, s);
    tick(29);
    chk("busy_pre_reset", busy[0], 1);
    reset = 1'b0;
    tick();
    chk("abort_wr_en", wr_en[0], 0);
    chk("abort_busy", busy[0], 0);
    chk("abort_step", step_count[0], 0);
    reset = 1'b1;
    tick();
    go(0, s);
    chk("regen_first_addr", wr_addr[0], 0);
    wait_done(0);
    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
